sync_fifo_param: RTL

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through read mode and programmable almost-full/almost-empty thresholds. It also adds a synchronous flush, sticky overflow/underflow error flags, and write-through when full with a simultaneous read. It sits between producer/consumer datapath stages that share clk.

---
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sync_fifo_param_if
// Brief    : Write/read/status bundle shared by a FIFO and its datapath neighbours.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          flush;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic          underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, dout_vld, full, empty, almost_full, almost_empty,
        input  fifo_cnt, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, dout_vld, full, empty, almost_full, almost_empty,
        output fifo_cnt, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sync_fifo_param
// Brief    : Single-clock FIFO, any depth >= 2, standard or FWFT read, thresholds.
// Revision : 1.0
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DW     = 16,
    parameter int DEPTH  = 8,
    parameter int FWFT   = 0,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    sync_fifo_param_if.slave    bus
);
    localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] c_LAST_PTR = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic [DW-1:0] w_head;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_rd_ok = bus.rd_en & ~w_empty & ~bus.flush;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign w_wr_ok = bus.wr_en & ~bus.flush & (~w_full | w_rd_ok);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (bus.wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head is zeroed while empty so reset and flush present a clean bus.
            assign bus.dout     = w_empty ? '0 : w_head;
            assign bus.dout_vld = ~w_empty;
        end else begin : g_std
            logic [DW-1:0] r_dout;
            logic          r_dout_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout     <= '0;
                    r_dout_vld <= 1'b0;
                end else if (bus.flush) begin
                    r_dout     <= '0;
                    r_dout_vld <= 1'b0;
                end else if (w_rd_ok) begin
                    r_dout     <= w_head;
                    r_dout_vld <= 1'b1;
                end else begin
                    r_dout_vld <= 1'b0;
                end
            end

            assign bus.dout     = r_dout;
            assign bus.dout_vld = r_dout_vld;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_cnt >= CW'(AF_LVL));
    assign bus.almost_empty = (r_cnt <= CW'(AE_LVL));
    assign bus.fifo_cnt     = r_cnt;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire
